// File: rtl/dino_pkg.sv
// dino_pkg: shared state encoding, segment patterns and digit count for the score display.
package dino_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam int NUM_DIGITS = 5;
  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
endpackage

// File: rtl/dino_score_display_seg7_decode.sv
// seg7_decode: combinational BCD nibble to 7-segment pattern; 10..15 go dark.
module seg7_decode
  import dino_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h00;
    case (i_nib)
      4'd0: o_seg = SEG_DIGIT[0];
      4'd1: o_seg = SEG_DIGIT[1];
      4'd2: o_seg = SEG_DIGIT[2];
      4'd3: o_seg = SEG_DIGIT[3];
      4'd4: o_seg = SEG_DIGIT[4];
      4'd5: o_seg = SEG_DIGIT[5];
      4'd6: o_seg = SEG_DIGIT[6];
      4'd7: o_seg = SEG_DIGIT[7];
      4'd8: o_seg = SEG_DIGIT[8];
      4'd9: o_seg = SEG_DIGIT[9];
      default: o_seg = 7'h00;
    endcase
  end
endmodule

// File: rtl/dino_score_display.sv
// dino_score_display: samples the binary score per frame, converts it to BCD by
// sequential double-dabble and scans it onto a 5-digit multiplexed 7-segment display.
module dino_score_display
  import dino_pkg::*;
#(
  parameter int REFRESH_DIV = 1024,
  parameter bit LZB         = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [15:0] score,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd_out,
  output logic [6:0]  seg,
  output logic [4:0]  digit_en
);
  localparam int DW = $clog2(REFRESH_DIV);
  state_t          r_state;
  logic [15:0]     r_bin;
  logic [19:0]     r_bcd;
  logic [3:0]      r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [19:0]     r_bcd_out;
  logic [DW-1:0]   r_div;
  logic [2:0]      r_idx;
  logic [6:0]      r_seg;
  logic [4:0]      r_en;
  logic [19:0]     w_adj;
  logic [19:0]     w_hi;
  logic [6:0]      w_seg;
  logic            w_blank;
  logic            w_wrap;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3 : r_bcd[4*g +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (frame_tick) begin
          r_bin   <= score;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= SHIFT;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj[18:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= COMMIT;
        end
        COMMIT: begin
          r_bcd_out <= r_bcd;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Digits at and above the scanned one, right-aligned; zero means leading-zero run.
  assign w_hi    = r_bcd_out >> {r_idx, 2'b00};
  assign w_blank = LZB && (r_idx != 3'd0) && (w_hi == 20'd0);
  assign w_wrap  = (r_div == DW'(REFRESH_DIV - 1));
  seg7_decode u_dec (
    .i_nib (w_hi[3:0]),
    .o_seg (w_seg)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
      r_seg <= '0;
      r_en  <= '0;
    end else begin
      r_div <= w_wrap ? '0 : r_div + DW'(1);
      if (w_wrap) r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
      r_seg <= w_blank ? 7'h00 : w_seg;
      r_en  <= w_blank ? 5'b00000 : 5'b00001 << r_idx;
    end
  end
  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd_out;
  assign seg      = r_seg;
  assign digit_en = r_en;
endmodule

// File: tb/tb_dino_score_display.sv
// tb_dino_score_display: randomized self-checking bench against a decimal-arithmetic model,
// with one DUT blanking leading zeros and one showing all digits.
module tb_dino_score_display;
  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [15:0] score;
  logic        busy1, done1, busy0, done0;
  logic [19:0] bcd1, bcd0;
  logic [6:0]  seg1, seg0;
  logic [4:0]  en1, en0;
  int cmp = 0;
  int err = 0;
  int cyc = 0;
  localparam logic [6:0] SEG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  dino_score_display #(.REFRESH_DIV(4), .LZB(1'b1)) u_lzb (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .score(score),
    .busy(busy1), .done(done1), .bcd_out(bcd1), .seg(seg1), .digit_en(en1));
  dino_score_display #(.REFRESH_DIV(4), .LZB(1'b0)) u_all (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .score(score),
    .busy(busy0), .done(done0), .bcd_out(bcd0), .seg(seg0), .digit_en(en0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
    return r;
  endfunction

  // Expected display after the k-th post-reset edge: each digit lit for 4 edges, one edge of lag.
  function automatic void exp_disp(input int v, input bit lzb, input int k,
                                   output logic [6:0] s, output logic [4:0] e);
    int idx = ((k - 1) / 4) % 5;
    int d   = (v / (10 ** idx)) % 10;
    bit blank = lzb && idx > 0 && v < 10 ** idx;
    s = blank ? 7'h00 : SEG[d];
    e = blank ? 5'b0 : 5'(1 << idx);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 1'b0; score = '0;
    repeat (3) step();
    cmp += 4;
    if (busy1 !== 1'b0) begin err++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    if (bcd1 !== 20'h0) begin err++; $display("FAIL reset_bcd: got %h expected 00000", bcd1); end
    if (seg1 !== 7'h00) begin err++; $display("FAIL reset_seg: got %h expected 00", seg1); end
    if (en1 !== 5'b0) begin err++; $display("FAIL reset_en: got %b expected 00000", en1); end
    rst = 1'b0;
    step();
    cmp += 4;
    if (en1 !== 5'b00001) begin err++; $display("FAIL post_reset_en: got %b expected 00001", en1); end
    if (seg1 !== 7'h3F) begin err++; $display("FAIL post_reset_seg: got %h expected 3f", seg1); end
    if (en0 !== 5'b00001) begin err++; $display("FAIL post_reset_en_all: got %b expected 00001", en0); end
    if (seg0 !== 7'h3F) begin err++; $display("FAIL post_reset_seg_all: got %h expected 3f", seg0); end
  endtask

  task automatic test_convert(input logic [15:0] s);
    int bcyc = 0;
    int dcnt = 0;
    score = s; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (busy1) bcyc++;
      if (done1) dcnt++;
      step();
    end
    cmp += 4;
    if (bcyc != 17) begin err++; $display("FAIL conv_busy(%0d): got %0d cycles expected 17", s, bcyc); end
    if (dcnt != 1) begin err++; $display("FAIL conv_done(%0d): got %0d pulses expected 1", s, dcnt); end
    if (bcd1 !== to_bcd(s)) begin err++; $display("FAIL conv_bcd(%0d): got %h expected %h", s, bcd1, to_bcd(s)); end
    if (bcd0 !== to_bcd(s)) begin err++; $display("FAIL conv_bcd_all(%0d): got %h expected %h", s, bcd0, to_bcd(s)); end
  endtask

  task automatic test_boundaries();
    test_convert(16'd12345);
    test_convert(16'd65535);
    test_convert(16'd0);
    test_convert(16'd10);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      test_convert(16'($urandom_range(0, 65535) >> $urandom_range(0, 15)));
  endtask

  task automatic test_dropped();
    int dcnt = 0;
    int second = -1;
    score = 16'd100; frame_tick = 1'b1;
    step();
    score = 16'd200;
    for (int e = 1; e <= 40; e++) begin
      frame_tick = (e == 5 || e == 17 || e == 18);
      step();
      if (done1) begin
        dcnt++;
        if (dcnt == 2) second = e;
      end
      if (e == 17) begin
        cmp += 2;
        if (done1 !== 1'b1) begin err++; $display("FAIL drop_first_done: got %b expected 1", done1); end
        if (bcd1 !== 20'h00100) begin err++; $display("FAIL drop_first_bcd: got %h expected 00100", bcd1); end
      end
    end
    frame_tick = 1'b0;
    cmp += 3;
    if (dcnt != 2) begin err++; $display("FAIL drop_done_count: got %0d expected 2", dcnt); end
    if (second != 35) begin err++; $display("FAIL drop_second_edge: got %0d expected 35", second); end
    if (bcd1 !== 20'h00200) begin err++; $display("FAIL drop_final_bcd: got %h expected 00200", bcd1); end
  endtask

  task automatic check_scan(input int v, input int ncyc);
    logic [6:0] s;
    logic [4:0] e;
    for (int i = 0; i < ncyc; i++) begin
      exp_disp(v, 1'b1, cyc, s, e);
      cmp += 2;
      if (seg1 !== s) begin err++; $display("FAIL scan_seg_lzb(%0d,cyc %0d): got %h expected %h", v, cyc, seg1, s); end
      if (en1 !== e) begin err++; $display("FAIL scan_en_lzb(%0d,cyc %0d): got %b expected %b", v, cyc, en1, e); end
      exp_disp(v, 1'b0, cyc, s, e);
      cmp += 2;
      if (seg0 !== s) begin err++; $display("FAIL scan_seg_all(%0d,cyc %0d): got %h expected %h", v, cyc, seg0, s); end
      if (en0 !== e) begin err++; $display("FAIL scan_en_all(%0d,cyc %0d): got %b expected %b", v, cyc, en0, e); end
      step();
    end
  endtask

  task automatic test_scan();
    int v;
    rst = 1'b1; step(); rst = 1'b0;
    test_convert(16'd7);
    check_scan(7, 40);
    for (int n = 0; n < 4; n++) begin
      v = $urandom_range(0, 65535) % (10 ** $urandom_range(1, 5));
      test_convert(16'(v));
      check_scan(v, 20);
    end
  endtask

  task automatic test_reset_mid();
    int dcnt = 0;
    int bcnt = 0;
    score = 16'd54321; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (7) step();
    rst = 1'b1; frame_tick = 1'b1;
    step();
    rst = 1'b0; frame_tick = 1'b0;
    cmp += 3;
    if (busy1 !== 1'b0) begin err++; $display("FAIL mid_busy: got %b expected 0", busy1); end
    if (bcd1 !== 20'h0) begin err++; $display("FAIL mid_bcd: got %h expected 00000", bcd1); end
    if (done1 !== 1'b0) begin err++; $display("FAIL mid_done: got %b expected 0", done1); end
    for (int i = 0; i < 25; i++) begin
      if (done1) dcnt++;
      if (busy1) bcnt++;
      step();
    end
    cmp += 3;
    if (dcnt != 0) begin err++; $display("FAIL mid_late_done: got %0d expected 0", dcnt); end
    if (bcnt != 0) begin err++; $display("FAIL mid_late_busy: got %0d expected 0", bcnt); end
    if (bcd1 !== 20'h0) begin err++; $display("FAIL mid_late_bcd: got %h expected 00000", bcd1); end
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_random();
    test_dropped();
    test_scan();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/dino_score_display.md
# dino_score_display

Display-side reader of the dino game's 16-bit binary score bus. Samples the score once per frame tick and converts it to 5-digit BCD with a sequential double-dabble engine. Drives a time-multiplexed 5-digit common-cathode 7-segment display with optional leading-zero blanking. Sits on the board or FPGA side, downstream of the score counter's output pins.

## Interface
- `REFRESH_DIV`, default 1024: clock cycles each digit stays lit; minimum 2.
- `LZB`, default 1: 1 blanks leading zeros; 0 shows all five digits.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `frame_tick` input 1: one-cycle pulse; requests a score sample.
- `score` input 16: unsigned binary score; stable in any cycle where `frame_tick`=1.
- `busy` output 1: conversion in progress.
- `done` output 1: one-cycle pulse when `bcd_out` updates.
- `bcd_out` output 20: displayed value; digit 4 in [19:16] down to digit 0 in [3:0].
- `seg` output 7: segments {g,f,e,d,c,b,a}; active-high.
- `digit_en` output 5: one-hot digit enable, bit i lights digit i; active-high.

## Operation
- **FSM states:** IDLE, SHIFT, COMMIT.
- **IDLE:** when `frame_tick`=1, load `score` into a 16-bit shift register, clear the 20-bit BCD accumulator, set `bit_cnt`=0, and go to SHIFT. Otherwise stay in IDLE.
- **SHIFT:** each cycle, add 3 to every BCD nibble that is ≥5. Then shift {bcd, bin} left by 1 as one 36-bit value. Increment `bit_cnt`. After the 16th shift (`bit_cnt`=15 at that edge), go to COMMIT.
- **COMMIT:** load the accumulator into `bcd_out`, pulse `done`, and return to IDLE.
- **Ticks while busy:** a `frame_tick` in SHIFT or COMMIT is dropped. It is neither queued nor counted.
- **Arithmetic range:** 0..65535 always fits in 5 BCD digits, so no overflow path exists.
- **Scan:** a divider counter runs 0..REFRESH_DIV-1 continuously. On wrap, the digit index advances 0→1→2→3→4→0.
- **Segment outputs:** `seg` and `digit_en` are registered and are recomputed from the current index and `bcd_out` every cycle.
- **Blanking:** with LZB=1, digit i>0 is blanked when digits i..4 of `bcd_out` are all zero. A blanked digit drives `digit_en`=0 and `seg`=0. Digit 0 is never blanked.
- **Nibble decode:** only 0..9 can occur. Values 10..15 decode to `seg`=0.

## Timing
- **Reset values:**
  - `busy`=0, `done`=0, `bcd_out`=0.
  - State IDLE; divider and digit index = 0.
  - `seg`=7'h00 and `digit_en`=5'b00000 during reset; from the first post-reset edge, `seg`=7'h3F and `digit_en`=5'b00001 (zero on digit 0).
- **Conversion latency:** tick sampled at edge E0; shifts occur at E1..E16; COMMIT at E17 updates `bcd_out` and raises `done` for the cycle after E17.
- **`busy`:** high from after E0 through after E17, i.e. 17 cycles.
- **Next accepted tick:** the earliest is the one sampled at E18. A tick at E17 is dropped.
- **Display update:** `seg` reflects a new `bcd_out` one cycle after COMMIT. There is no mid-digit tearing beyond that single cycle.
- **Reset mid-conversion:** returns to IDLE, clears `bcd_out`, and discards the partial result. A `frame_tick` coincident with `rst` is ignored.

## Structure
- **Shared package `dino_pkg`:** state enum (IDLE/SHIFT/COMMIT), the `SEG_DIGIT[0:9]` 7-bit segment constants, and `NUM_DIGITS`=5.
- **Sub-module `seg7_decode`:** combinational 4-bit to 7-bit decoder.
- **Top level:** contains the FSM, the double-dabble datapath and the scan logic.

## Test plan
- **Reset:** assert `rst` 3 cycles → `busy`=0, `bcd_out`=0; after release `digit_en`=00001, `seg`=7'h3F.
- **Conversion 12345:** `score`=12345, tick → `busy` high exactly 17 cycles, `done` pulses once, `bcd_out`=20'h12345.
- **Boundary values:** `score`=65535 → `bcd_out`=20'h65535; `score`=0 → 20'h00000; `score`=10 → 20'h00010.
- **Dropped ticks:** with `score`=100, tick, then score=200 with ticks at E5 and E17 → `bcd_out`=20'h00100, only one `done`. A tick at E18 with `score`=200 → 20'h00200.
- **Scan and blanking:** REFRESH_DIV=4, LZB=1, `score`=7. Digit 0 shows `seg`=7'h07 for 4 cycles, and the next 16 cycles have `digit_en`=0. With LZB=0, digits 1..4 show 7'h3F in turn.
- **Reset mid-conversion:** pulse `rst` at E8 → `busy`=0 the next cycle, no `done`, `bcd_out`=0.
